// File: rtl/wallace_mult_pipe_if.sv
// Operand/product handshake bundle for wallace_mult_pipe.
// The master side drives operands and consumes products; the slave is the multiplier.
interface wallace_mult_pipe_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               in_signed;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] p;

  modport master (
    output in_valid, a, b, in_signed, out_ready,
    input  in_ready, out_valid, p
  );

  modport slave (
    input  in_valid, a, b, in_signed, out_ready,
    output in_ready, out_valid, p
  );
endinterface

// File: rtl/wallace_mult_pipe.sv
// Three-stage pipelined WIDTH x WIDTH Wallace-tree multiplier, valid/ready on both sides.
// Define WALLACE_SIGNED_EN to honour in_signed (Baugh-Wooley); otherwise operands are unsigned.
module wallace_mult_pipe #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  wallace_mult_pipe_if.slave bus
);
  localparam int W2 = 2 * WIDTH;
  localparam int NR = WIDTH + 1;  // partial-product rows plus one correction row

  typedef logic [W2-1:0] row_t;

  logic                     advance;
  logic                     v1, v2, v3;
  logic [WIDTH*WIDTH-1:0]   pp_d, pp_q;
  row_t                     row0_d, row1_d, row0_q, row1_q;
  row_t                     p_q;

  // Handshake: a beat transfers on an edge where valid && ready. The pipe moves as one
  // unit, so the input side is ready exactly when the output register is empty or draining.
  assign advance       = !v3 || bus.out_ready;
  assign bus.in_ready  = advance;
  assign bus.out_valid = v3;
  assign bus.p         = p_q;

`ifdef WALLACE_SIGNED_EN
  localparam row_t CORR = (row_t'(1) << WIDTH) | (row_t'(1) << (W2 - 1));
  logic sgn_q;
`else
  logic unused_in_signed;
  assign unused_in_signed = bus.in_signed;
`endif

  always_comb begin
    pp_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        pp_d[i*WIDTH + j] = bus.a[j] & bus.b[i];
`ifdef WALLACE_SIGNED_EN
        // Baugh-Wooley: bits pairing exactly one sign bit enter inverted.
        if (bus.in_signed && ((i == WIDTH - 1) != (j == WIDTH - 1)))
          pp_d[i*WIDTH + j] = ~(bus.a[j] & bus.b[i]);
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      pp_q <= '0;
    end else if (advance) begin
      v1   <= bus.in_valid;
      pp_q <= pp_d;
    end
  end

`ifdef WALLACE_SIGNED_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       sgn_q <= 1'b0;
    else if (advance) sgn_q <= bus.in_signed;
  end
`endif

  // Wallace reduction: each level compresses every full group of three rows into a
  // sum row and a shifted carry row; leftover rows pass through to the next level.
  always_comb begin
    row_t cur [NR];
    row_t nxt [NR];
    int   n;
    for (int r = 0; r < NR; r++) begin
      cur[r] = '0;
      nxt[r] = '0;
    end
    for (int i = 0; i < WIDTH; i++)
      cur[i] = row_t'(pp_q[i*WIDTH +: WIDTH]) << i;
`ifdef WALLACE_SIGNED_EN
    cur[WIDTH] = sgn_q ? CORR : '0;
`else
    cur[WIDTH] = '0;
`endif
    n = NR;
    for (int lvl = 0; lvl < NR; lvl++) begin
      if (n > 2) begin
        for (int r = 0; r < NR; r++) nxt[r] = '0;
        for (int g = 0; g < NR / 3; g++) begin
          if (3*g + 2 < n) begin
            nxt[2*g]     = cur[3*g] ^ cur[3*g+1] ^ cur[3*g+2];
            nxt[2*g + 1] = ((cur[3*g] & cur[3*g+1]) | (cur[3*g] & cur[3*g+2]) |
                            (cur[3*g+1] & cur[3*g+2])) << 1;
          end
        end
        for (int r = 0; r < 2; r++) begin
          if ((n / 3) * 3 + r < n) nxt[(n / 3) * 2 + r] = cur[(n / 3) * 3 + r];
        end
        for (int r = 0; r < NR; r++) cur[r] = nxt[r];
        n = (n / 3) * 2 + (n % 3);
      end
    end
    row0_d = cur[0];
    row1_d = cur[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2     <= 1'b0;
      row0_q <= '0;
      row1_q <= '0;
    end else if (advance) begin
      v2     <= v1;
      row0_q <= row0_d;
      row1_q <= row1_d;
    end
  end

  // Final carry-propagate add; the carry out of the top bit is dropped by the width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3  <= 1'b0;
      p_q <= '0;
    end else if (advance) begin
      v3  <= v2;
      p_q <= row0_q + row1_q;
    end
  end
endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Bench for wallace_mult_pipe: WIDTH=8 directed/random/back-pressure/reset checks plus
// streaming sweeps at WIDTH=4 (exhaustive), 16, 17 and 32 against an arithmetic model.
module tb_wallace_mult_pipe;
  localparam int WM = 8;
`ifdef WALLACE_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic sweep_go = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  wallace_mult_pipe_if #(.WIDTH(WM)) m ();
  wallace_mult_pipe #(.WIDTH(WM)) u_dut (.clk(clk), .rst_n(rst_n), .bus(m));

  // Product of two w-bit operands, modulo 2^(2w), using plain 64-bit arithmetic.
  function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                          input int w, input bit s);
    logic [63:0] mw, mp, ea, eb;
    mw = (64'd1 << w) - 64'd1;
    ea = a & mw;
    eb = b & mw;
    if (s && SGN) begin
      if (a[w-1]) ea = ea | ~mw;
      if (b[w-1]) eb = eb | ~mw;
    end
    mp = (2*w >= 64) ? '1 : ((64'd1 << (2*w)) - 64'd1);
    return (ea * eb) & mp;
  endfunction

  task automatic chk_v(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    chk_v(name, 64'(act), 64'(exp));
  endtask

  // Scoreboard for the WIDTH=8 instance.
  logic [2*WM-1:0] exp_q[$];
  int   out_cnt = 0;
  int   run = 0;
  int   last_run = 0;
  bit   prev_stall = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
      run = 0;
    end else begin
      if (prev_stall) chk_b("stall_valid_held", m.out_valid, 1'b1);
      prev_stall = m.out_valid && !m.out_ready;
      if (m.out_valid) begin
        run++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_out: got p=%0h with no product owed", m.p);
        end else begin
          chk_v("p_vs_model", 64'(m.p), 64'(exp_q[0]));
          if (m.out_ready) begin
            out_cnt++;
            void'(exp_q.pop_front());
          end
        end
      end else begin
        if (run != 0) last_run = run;
        run = 0;
      end
      if (m.in_valid && m.in_ready)
        exp_q.push_back((2*WM)'(ref_mul(64'(m.a), 64'(m.b), WM, m.in_signed)));
    end
  end

  // Present one operand pair and hold it until the DUT takes it (bounded wait).
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s);
    bit acc;
    int w;
    m.in_valid = 1'b1;
    m.a = a;
    m.b = b;
    m.in_signed = s;
    acc = 1'b0;
    w = 0;
    while (!acc && w < 200) begin
      @(negedge clk);
      acc = m.in_ready;
      @(posedge clk);
      #1;
      w++;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles, want acceptance", w);
    end
  endtask

  // Streaming sweeps at other widths, always ready downstream.
  for (genvar gi = 0; gi < 4; gi++) begin : g_sweep
    localparam int W = (gi == 0) ? 4 : (gi == 1) ? 16 : (gi == 2) ? 17 : 32;
    localparam int N = (W == 4) ? 512 : 300;
    wallace_mult_pipe_if #(.WIDTH(W)) sif ();
    wallace_mult_pipe #(.WIDTH(W)) u_dut (.clk(clk), .rst_n(rst_n), .bus(sif));
    logic [2*W-1:0] q[$];
    int n_out = 0;
    bit done = 1'b0;

    initial begin
      sif.in_valid = 1'b0;
      sif.a = '0;
      sif.b = '0;
      sif.in_signed = 1'b0;
      sif.out_ready = 1'b1;
      wait (sweep_go);
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
        sif.in_valid = 1'b1;
        if (W == 4) begin
          sif.a = W'(k);
          sif.b = W'(k >> 4);
          sif.in_signed = k[8];
        end else begin
          sif.a = W'($urandom());
          sif.b = W'($urandom());
          sif.in_signed = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        #1;
      end
      sif.in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      chk_v($sformatf("sweep%0d_count", W), 64'(n_out), 64'(N));
      chk_v($sformatf("sweep%0d_leftover", W), 64'(q.size()), 64'd0);
      done = 1'b1;
    end

    always @(negedge clk) begin
      if (rst_n) begin
        if (sif.out_valid && sif.out_ready) begin
          n_out++;
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sweep%0d_spurious: got p=%0h with no product owed", W, sif.p);
          end else begin
            chk_v($sformatf("sweep%0d_p", W), 64'(sif.p), 64'(q.pop_front()));
          end
        end
        if (sif.in_valid && sif.in_ready)
          q.push_back((2*W)'(ref_mul(64'(sif.a), 64'(sif.b), W, sif.in_signed)));
      end
    end
  end

  initial begin
    vec_t tbl[7];
    logic [7:0] ba[4];
    logic [7:0] bb[4];
    logic       bs[4];
    logic [15:0] exp0;
    int  cnt0;
    int  w;
    bit  send_done;

    tbl[0] = '{a: 8'hFF, b: 8'hFF, s: 1'b0, exp: 16'hFE01};
    tbl[1] = '{a: 8'h00, b: 8'hAB, s: 1'b0, exp: 16'h0000};
    tbl[2] = '{a: 8'hFF, b: 8'h01, s: 1'b0, exp: 16'h00FF};
    tbl[3] = '{a: 8'h80, b: 8'h80, s: 1'b1, exp: 16'h4000};
    tbl[4] = '{a: 8'hFF, b: 8'h01, s: 1'b1, exp: SGN ? 16'hFFFF : 16'h00FF};
    tbl[5] = '{a: 8'h7F, b: 8'h80, s: 1'b1, exp: SGN ? 16'hC080 : 16'h3F80};
    tbl[6] = '{a: 8'h80, b: 8'hFF, s: 1'b1, exp: SGN ? 16'h0080 : 16'h7F80};

    // Clock/reset
    m.in_valid = 1'b0;
    m.a = '0;
    m.b = '0;
    m.in_signed = 1'b0;
    m.out_ready = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk_b("reset_in_ready", m.in_ready, 1'b1);
    chk_b("reset_out_valid", m.out_valid, 1'b0);
    chk_v("reset_p", 64'(m.p), 64'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed vectors with exact latency: valid after the third edge counting the accept edge.
    for (int i = 0; i < 7; i++) begin
      m.in_valid = 1'b1;
      m.a = tbl[i].a;
      m.b = tbl[i].b;
      m.in_signed = tbl[i].s;
      chk_b("tbl_in_ready", m.in_ready, 1'b1);
      @(posedge clk);
      #1 m.in_valid = 1'b0;
      chk_b("tbl_lat_e0", m.out_valid, 1'b0);
      @(posedge clk);
      #1 chk_b("tbl_lat_e1", m.out_valid, 1'b0);
      @(posedge clk);
      #1 chk_b("tbl_lat_e2", m.out_valid, 1'b1);
      chk_v($sformatf("tbl%0d_p", i), 64'(m.p), 64'(tbl[i].exp));
      @(posedge clk);
      #1 chk_b("tbl_drained", m.out_valid, 1'b0);
    end

    // Back-to-back stream of 10 random pairs.
    cnt0 = out_cnt;
    for (int i = 0; i < 10; i++) begin
      m.in_valid = 1'b1;
      m.a = 8'($urandom());
      m.b = 8'($urandom());
      m.in_signed = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    m.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk_v("stream_count", 64'(out_cnt - cnt0), 64'd10);
    chk_v("stream_run_len", 64'(last_run), 64'd10);
    chk_v("stream_leftover", 64'(exp_q.size()), 64'd0);

    // Back-pressure: fill the pipe with out_ready low, hold 5 cycles, release.
    cnt0 = out_cnt;
    m.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ba[i] = 8'($urandom());
      bb[i] = 8'($urandom());
      bs[i] = 1'($urandom_range(0, 1));
    end
    exp0 = 16'(ref_mul(64'(ba[0]), 64'(bb[0]), WM, bs[0]));
    for (int i = 0; i < 3; i++) send(ba[i], bb[i], bs[i]);
    m.in_valid = 1'b1;
    m.a = ba[3];
    m.b = bb[3];
    m.in_signed = bs[3];
    chk_b("bp_full_in_ready", m.in_ready, 1'b0);
    repeat (5) begin
      @(posedge clk);
      #1;
      chk_b("bp_in_ready", m.in_ready, 1'b0);
      chk_b("bp_out_valid", m.out_valid, 1'b1);
      chk_v("bp_p_held", 64'(m.p), 64'(exp0));
    end
    m.out_ready = 1'b1;
    @(posedge clk);
    #1 m.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk_v("bp_count", 64'(out_cnt - cnt0), 64'd4);
    chk_v("bp_leftover", 64'(exp_q.size()), 64'd0);

    // Random out_ready toggling with a stream of 30 sends.
    cnt0 = out_cnt;
    send_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 30; i++)
          send(8'($urandom()), 8'($urandom()), 1'($urandom_range(0, 1)));
        m.in_valid = 1'b0;
        send_done = 1'b1;
      end
      begin
        w = 0;
        while (!send_done && w < 2000) begin
          @(posedge clk);
          #1 m.out_ready = 1'($urandom_range(0, 1));
          w++;
        end
        m.out_ready = 1'b1;
      end
    join
    m.out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk_v("toggle_count", 64'(out_cnt - cnt0), 64'd30);
    chk_v("toggle_leftover", 64'(exp_q.size()), 64'd0);

    // Reset with three operations in flight.
    m.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(8'($urandom()), 8'($urandom()), 1'b0);
    m.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_b("midrst_out_valid", m.out_valid, 1'b0);
    chk_v("midrst_p", 64'(m.p), 64'd0);
    chk_b("midrst_in_ready", m.in_ready, 1'b1);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cnt0 = out_cnt;
    send(8'hC3, 8'h5A, 1'b0);
    m.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk_v("midrst_count", 64'(out_cnt - cnt0), 64'd1);
    chk_v("midrst_leftover", 64'(exp_q.size()), 64'd0);

    // Width sweeps.
    sweep_go = 1'b1;
    w = 0;
    while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done && g_sweep[3].done)
           && w < 3000) begin
      @(posedge clk);
      w++;
    end
    if (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done && g_sweep[3].done)) begin
      total++;
      bad++;
      $display("FAIL sweep_timeout: got unfinished sweeps after %0d cycles, want all done", w);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
